// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the issue stage and the branch resolve unit.
// The issuing side uses the master modport; the unit itself uses slave.
interface branch_resolve_unit_if #(
   parameter int XLEN = 32
);
   logic            in_valid_i;
   logic            in_ready_o;
   logic [3:0]      op_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] imm_i;
   logic            pred_taken_i;
   logic [XLEN-1:0] pred_target_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic            taken_o;
   logic [XLEN-1:0] target_o;
   logic [XLEN-1:0] link_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            mispredict_o;

   modport master (
      output in_valid_i, op_i, op1_i, op2_i, pc_i, imm_i,
             pred_taken_i, pred_target_i, out_ready_i,
      input  in_ready_o, out_valid_o, taken_o, target_o, link_o,
             redirect_pc_o, mispredict_o
   );

   modport slave (
      input  in_valid_i, op_i, op1_i, op2_i, pc_i, imm_i,
             pred_taken_i, pred_target_i, out_ready_i,
      output in_ready_o, out_valid_o, taken_o, target_o, link_o,
             redirect_pc_o, mispredict_o
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branch/jump outcome and target in one registered stage, flags
// mispredictions against the front-end guess and keeps saturating statistics.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 stat_clr_i,
   output logic [CNT_W-1:0]     stat_branches_o,
   output logic [CNT_W-1:0]     stat_mispred_o,
   branch_resolve_unit_if.slave bus
);
   localparam logic [3:0] OP_BEQ  = 4'd1;
   localparam logic [3:0] OP_BNE  = 4'd2;
   localparam logic [3:0] OP_BLT  = 4'd3;
   localparam logic [3:0] OP_BGE  = 4'd4;
   localparam logic [3:0] OP_BLTU = 4'd5;
   localparam logic [3:0] OP_BGEU = 4'd6;
   localparam logic [3:0] OP_JAL  = 4'd7;
   localparam logic [3:0] OP_JALR = 4'd8;

   localparam logic [XLEN-1:0]  FOUR    = XLEN'(4);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic            accept;
   logic            drain;
   logic            valid_op;
   logic            taken_c;
   logic            mispred_c;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_plus_imm;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target_c;

   logic            valid_q;
   logic            taken_q;
   logic            mispred_q;
   logic            counted_q;
   logic [XLEN-1:0] target_q;
   logic [XLEN-1:0] link_q;
   logic [XLEN-1:0] redirect_q;
   logic [CNT_W-1:0] br_cnt_q;
   logic [CNT_W-1:0] mp_cnt_q;

   assign bus.in_ready_o = !valid_q || bus.out_ready_i;
   assign accept         = bus.in_valid_i && bus.in_ready_o;
   assign drain          = valid_q && bus.out_ready_i;

   assign pc_plus4    = bus.pc_i + FOUR;
   assign pc_plus_imm = bus.pc_i + bus.imm_i;
   assign jalr_sum    = bus.op1_i + bus.imm_i;

   always_comb begin
      taken_c  = 1'b0;
      target_c = pc_plus4;
      valid_op = 1'b1;
      unique case (bus.op_i)
         OP_BEQ:  begin taken_c = (bus.op1_i == bus.op2_i);                   target_c = pc_plus_imm; end
         OP_BNE:  begin taken_c = (bus.op1_i != bus.op2_i);                   target_c = pc_plus_imm; end
         OP_BLT:  begin taken_c = ($signed(bus.op1_i) <  $signed(bus.op2_i)); target_c = pc_plus_imm; end
         OP_BGE:  begin taken_c = ($signed(bus.op1_i) >= $signed(bus.op2_i)); target_c = pc_plus_imm; end
         OP_BLTU: begin taken_c = (bus.op1_i <  bus.op2_i);                   target_c = pc_plus_imm; end
         OP_BGEU: begin taken_c = (bus.op1_i >= bus.op2_i);                   target_c = pc_plus_imm; end
         OP_JAL:  begin taken_c = 1'b1;                                       target_c = pc_plus_imm; end
         OP_JALR: begin taken_c = 1'b1; target_c = {jalr_sum[XLEN-1:1], 1'b0}; end
         default: valid_op = 1'b0;
      endcase
   end

   // NONE and illegal opcodes never report a mispredict, whatever the guess.
   assign mispred_c = valid_op &&
                      ((taken_c != bus.pred_taken_i) ||
                       (taken_c && (target_c != bus.pred_target_i)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         taken_q    <= 1'b0;
         mispred_q  <= 1'b0;
         counted_q  <= 1'b0;
         target_q   <= '0;
         link_q     <= '0;
         redirect_q <= '0;
      end else begin
         if (flush_i)     valid_q <= 1'b0;
         else if (accept) valid_q <= 1'b1;
         else if (drain)  valid_q <= 1'b0;

         if (accept && !flush_i) begin
            taken_q    <= taken_c;
            mispred_q  <= mispred_c;
            counted_q  <= valid_op;
            target_q   <= target_c;
            link_q     <= pc_plus4;
            redirect_q <= taken_c ? target_c : pc_plus4;
         end
      end
   end

   // A handshake in the flush cycle still counts: the result was consumed.
   always_ff @(posedge clk_i) begin
      if (rst_i || stat_clr_i) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else if (drain && counted_q) begin
         if (br_cnt_q != CNT_MAX)              br_cnt_q <= br_cnt_q + CNT_ONE;
         if (mispred_q && mp_cnt_q != CNT_MAX) mp_cnt_q <= mp_cnt_q + CNT_ONE;
      end
   end

   assign bus.out_valid_o   = valid_q;
   assign bus.taken_o       = valid_q && taken_q;
   assign bus.mispredict_o  = valid_q && mispred_q;
   assign bus.target_o      = target_q;
   assign bus.link_o        = link_q;
   assign bus.redirect_pc_o = redirect_q;
   assign stat_branches_o   = br_cnt_q;
   assign stat_mispred_o    = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors, stalls,
// flush, reset, back-to-back throughput and counter saturation.
module tb_branch_resolve_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        stat_clr = 1'b0;
   logic [15:0] stat_br;
   logic [15:0] stat_mp;
   logic        flush2 = 1'b0;
   logic        clr2 = 1'b0;
   logic [1:0]  stat_br2;
   logic [1:0]  stat_mp2;
   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_br = 0;
   int          exp_mp = 0;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.XLEN(32)) bus ();
   branch_resolve_unit_if #(.XLEN(32)) bus2 ();

   branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .stat_clr_i(stat_clr),
      .stat_branches_o(stat_br), .stat_mispred_o(stat_mp), .bus(bus.slave));

   branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush2), .stat_clr_i(clr2),
      .stat_branches_o(stat_br2), .stat_mispred_o(stat_mp2), .bus(bus2.slave));

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, pc, imm;
      logic        pt;
      logic [31:0] ptg;
      logic        e_taken;
      logic [31:0] e_target;
      logic        e_mp;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg);
      bus.in_valid_i    = 1'b1;
      bus.op_i          = op;
      bus.op1_i         = a;
      bus.op2_i         = b;
      bus.pc_i          = pc;
      bus.imm_i         = imm;
      bus.pred_taken_i  = pt;
      bus.pred_target_i = ptg;
   endtask

   task automatic test_reset();
      drive(4'd3, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
      bus.out_ready_i = 1'b0;
      flush = 1'b1; stat_clr = 1'b1;
      tick(); tick();
      n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid_o); end
      n_cmp++; if (bus.taken_o !== 1'b0 || bus.mispredict_o !== 1'b0) begin n_err++; $display("FAIL reset_flags: got taken=%b mp=%b expected 0 0", bus.taken_o, bus.mispredict_o); end
      n_cmp++; if (bus.target_o !== 32'h0 || bus.link_o !== 32'h0 || bus.redirect_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h %h %h expected zeros", bus.target_o, bus.link_o, bus.redirect_pc_o); end
      n_cmp++; if (stat_br !== 16'd0 || stat_mp !== 16'd0) begin n_err++; $display("FAIL reset_stats: got %0d %0d expected 0 0", stat_br, stat_mp); end
      rst = 1'b0; flush = 1'b0; stat_clr = 1'b0;
      bus.in_valid_i = 1'b0;
      #1;
      n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready_o); end
   endtask

   task automatic test_blt();
      bus.out_ready_i = 1'b1;
      drive(4'd3, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
      tick();
      bus.in_valid_i = 1'b0;
      n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.taken_o !== 1'b1 || bus.mispredict_o !== 1'b1) begin n_err++; $display("FAIL blt_flags: got v=%b t=%b mp=%b expected 1 1 1", bus.out_valid_o, bus.taken_o, bus.mispredict_o); end
      n_cmp++; if (bus.target_o !== 32'h120 || bus.redirect_pc_o !== 32'h120 || bus.link_o !== 32'h104) begin n_err++; $display("FAIL blt_data: got tgt=%h rd=%h lk=%h expected 120 120 104", bus.target_o, bus.redirect_pc_o, bus.link_o); end
      tick();
      exp_br++; exp_mp++;
      n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.taken_o !== 1'b0 || bus.mispredict_o !== 1'b0) begin n_err++; $display("FAIL blt_drain: got v=%b t=%b mp=%b expected 0 0 0", bus.out_valid_o, bus.taken_o, bus.mispredict_o); end
      n_cmp++; if (stat_br !== 16'(exp_br) || stat_mp !== 16'(exp_mp)) begin n_err++; $display("FAIL blt_stats: got %0d %0d expected %0d %0d", stat_br, stat_mp, exp_br, exp_mp); end
   endtask

   task automatic test_bltu();
      drive(4'd5, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
      tick();
      bus.in_valid_i = 1'b0;
      n_cmp++; if (bus.taken_o !== 1'b0 || bus.mispredict_o !== 1'b0) begin n_err++; $display("FAIL bltu_flags: got t=%b mp=%b expected 0 0", bus.taken_o, bus.mispredict_o); end
      n_cmp++; if (bus.redirect_pc_o !== 32'h104 || bus.link_o !== 32'h104 || bus.target_o !== 32'h120) begin n_err++; $display("FAIL bltu_data: got rd=%h lk=%h tgt=%h expected 104 104 120", bus.redirect_pc_o, bus.link_o, bus.target_o); end
      tick();
      exp_br++;
   endtask

   task automatic test_jalr();
      drive(4'd8, 32'h1001, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1004);
      tick();
      n_cmp++; if (bus.target_o !== 32'h1004 || bus.mispredict_o !== 1'b0 || bus.taken_o !== 1'b1 || bus.link_o !== 32'h204) begin n_err++; $display("FAIL jalr_hit: got tgt=%h mp=%b t=%b lk=%h expected 1004 0 1 204", bus.target_o, bus.mispredict_o, bus.taken_o, bus.link_o); end
      drive(4'd8, 32'h1001, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1000);
      tick();
      bus.in_valid_i = 1'b0;
      n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h1004) begin n_err++; $display("FAIL jalr_miss: got v=%b mp=%b rd=%h expected 1 1 1004", bus.out_valid_o, bus.mispredict_o, bus.redirect_pc_o); end
      tick();
      exp_br += 2; exp_mp += 1;
      n_cmp++; if (stat_br !== 16'(exp_br) || stat_mp !== 16'(exp_mp)) begin n_err++; $display("FAIL jalr_stats: got %0d %0d expected %0d %0d", stat_br, stat_mp, exp_br, exp_mp); end
   endtask

   task automatic test_ops();
      vec_t v[7];
      v[0] = '{4'd1, 32'h5, 32'h5, 32'h300, 32'h10, 1'b1, 32'h310, 1'b1, 32'h310, 1'b0};
      v[1] = '{4'd2, 32'h5, 32'h5, 32'h300, 32'h10, 1'b0, 32'h0, 1'b0, 32'h310, 1'b0};
      v[2] = '{4'd4, 32'h8000_0000, 32'h0, 32'h400, 32'h40, 1'b1, 32'h440, 1'b0, 32'h440, 1'b1};
      v[3] = '{4'd6, 32'h8000_0000, 32'h0, 32'h400, 32'h40, 1'b1, 32'h440, 1'b1, 32'h440, 1'b0};
      v[4] = '{4'd7, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1};
      v[5] = '{4'd0, 32'h0, 32'h0, 32'h500, 32'h80, 1'b1, 32'h580, 1'b0, 32'h504, 1'b0};
      v[6] = '{4'd12, 32'h1, 32'h1, 32'h600, 32'h80, 1'b1, 32'h680, 1'b0, 32'h604, 1'b0};
      for (int i = 0; i < 7; i++) begin
         logic [31:0] lk;
         logic [31:0] rd;
         lk = v[i].pc + 32'd4;
         rd = v[i].e_taken ? v[i].e_target : lk;
         drive(v[i].op, v[i].a, v[i].b, v[i].pc, v[i].imm, v[i].pt, v[i].ptg);
         tick();
         n_cmp++;
         if (bus.out_valid_o !== 1'b1 || bus.taken_o !== v[i].e_taken || bus.target_o !== v[i].e_target ||
             bus.mispredict_o !== v[i].e_mp || bus.link_o !== lk || bus.redirect_pc_o !== rd) begin
            n_err++;
            $display("FAIL op_vec%0d: got v=%b t=%b tgt=%h mp=%b lk=%h rd=%h expected 1 %b %h %b %h %h", i,
                     bus.out_valid_o, bus.taken_o, bus.target_o, bus.mispredict_o, bus.link_o, bus.redirect_pc_o,
                     v[i].e_taken, v[i].e_target, v[i].e_mp, lk, rd);
         end
      end
      bus.in_valid_i = 1'b0;
      tick();
      exp_br += 5; exp_mp += 2;
      n_cmp++; if (stat_br !== 16'(exp_br) || stat_mp !== 16'(exp_mp)) begin n_err++; $display("FAIL op_stats: got %0d %0d expected %0d %0d", stat_br, stat_mp, exp_br, exp_mp); end
   endtask

   task automatic test_stall();
      bus.out_ready_i = 1'b0;
      drive(4'd3, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
      tick();
      drive(4'd1, 32'h7, 32'h7, 32'h900, 32'h8, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.target_o !== 32'h120 ||
             bus.taken_o !== 1'b1 || bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h120 ||
             stat_br !== 16'(exp_br)) begin
            n_err++;
            $display("FAIL stall_hold%0d: got rdy=%b v=%b tgt=%h t=%b mp=%b rd=%h br=%0d expected 0 1 120 1 1 120 %0d", i,
                     bus.in_ready_o, bus.out_valid_o, bus.target_o, bus.taken_o, bus.mispredict_o, bus.redirect_pc_o, stat_br, exp_br);
         end
      end
      bus.in_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      #1;
      n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready_o); end
      tick();
      exp_br++; exp_mp++;
      n_cmp++; if (bus.out_valid_o !== 1'b0 || stat_br !== 16'(exp_br) || stat_mp !== 16'(exp_mp)) begin n_err++; $display("FAIL stall_release: got v=%b br=%0d mp=%0d expected 0 %0d %0d", bus.out_valid_o, stat_br, stat_mp, exp_br, exp_mp); end
      tick();
      n_cmp++; if (stat_br !== 16'(exp_br)) begin n_err++; $display("FAIL stall_once: got %0d expected %0d", stat_br, exp_br); end
   endtask

   task automatic test_flush_stall();
      bus.out_ready_i = 1'b0;
      drive(4'd1, 32'h3, 32'h3, 32'h700, 32'h10, 1'b0, 32'h0);
      tick();
      bus.in_valid_i = 1'b0;
      flush = 1'b1;
      #1;
      n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready_o); end
      tick();
      flush = 1'b0;
      n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.taken_o !== 1'b0) begin n_err++; $display("FAIL flush_drop: got v=%b t=%b expected 0 0", bus.out_valid_o, bus.taken_o); end
      bus.out_ready_i = 1'b1;
      tick();
      n_cmp++; if (stat_br !== 16'(exp_br) || stat_mp !== 16'(exp_mp)) begin n_err++; $display("FAIL flush_stats: got %0d %0d expected %0d %0d", stat_br, stat_mp, exp_br, exp_mp); end
   endtask

   task automatic test_back_to_back();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      n_cmp++; if (stat_br !== 16'd0 || stat_mp !== 16'd0) begin n_err++; $display("FAIL clr_stats: got %0d %0d expected 0 0", stat_br, stat_mp); end
      bus.out_ready_i = 1'b1;
      drive(4'd1, 32'h1, 32'h1, 32'h1000, 32'h100, 1'b1, 32'h1100);
      tick();
      n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.target_o !== 32'h1100) begin n_err++; $display("FAIL b2b_a: got v=%b tgt=%h expected 1 1100", bus.out_valid_o, bus.target_o); end
      drive(4'd1, 32'h1, 32'h1, 32'h2000, 32'h100, 1'b1, 32'h2100);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++; if (bus.out_valid_o !== 1'b0 || stat_br !== 16'd1) begin n_err++; $display("FAIL b2b_flush: got v=%b br=%0d expected 0 1", bus.out_valid_o, stat_br); end
      drive(4'd1, 32'h1, 32'h1, 32'h3000, 32'h100, 1'b1, 32'h3100);
      tick();
      n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.target_o !== 32'h3100) begin n_err++; $display("FAIL b2b_c: got v=%b tgt=%h expected 1 3100", bus.out_valid_o, bus.target_o); end
      drive(4'd1, 32'h1, 32'h1, 32'h4000, 32'h100, 1'b1, 32'h4100);
      tick();
      bus.in_valid_i = 1'b0;
      n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.target_o !== 32'h4100) begin n_err++; $display("FAIL b2b_d: got v=%b tgt=%h expected 1 4100", bus.out_valid_o, bus.target_o); end
      tick();
      n_cmp++; if (stat_br !== 16'd3 || stat_mp !== 16'd0) begin n_err++; $display("FAIL b2b_stats: got %0d %0d expected 3 0", stat_br, stat_mp); end
   endtask

   task automatic test_reset_stall();
      bus.out_ready_i = 1'b0;
      drive(4'd7, 32'h0, 32'h0, 32'h800, 32'h40, 1'b0, 32'h0);
      tick();
      bus.in_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.target_o !== 32'h0) begin n_err++; $display("FAIL rst_stall: got v=%b rdy=%b tgt=%h expected 0 1 0", bus.out_valid_o, bus.in_ready_o, bus.target_o); end
      bus.out_ready_i = 1'b1;
      tick();
      n_cmp++; if (stat_br !== 16'd0 || stat_mp !== 16'd0) begin n_err++; $display("FAIL rst_stall_stats: got %0d %0d expected 0 0", stat_br, stat_mp); end
   endtask

   task automatic test_saturate();
      bus2.out_ready_i   = 1'b1;
      bus2.in_valid_i    = 1'b1;
      bus2.op_i          = 4'd7;
      bus2.pc_i          = 32'h40;
      bus2.imm_i         = 32'h10;
      bus2.pred_taken_i  = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      bus2.in_valid_i = 1'b0;
      tick();
      n_cmp++; if (stat_br2 !== 2'd3 || stat_mp2 !== 2'd3) begin n_err++; $display("FAIL sat_stats: got %0d %0d expected 3 3", stat_br2, stat_mp2); end
      bus2.in_valid_i = 1'b1;
      tick();
      bus2.in_valid_i = 1'b0;
      clr2 = 1'b1;
      n_cmp++; if (bus2.out_valid_o !== 1'b1 || bus2.mispredict_o !== 1'b1) begin n_err++; $display("FAIL sat_pending: got v=%b mp=%b expected 1 1", bus2.out_valid_o, bus2.mispredict_o); end
      tick();
      clr2 = 1'b0;
      n_cmp++; if (stat_br2 !== 2'd0 || stat_mp2 !== 2'd0 || bus2.out_valid_o !== 1'b0) begin n_err++; $display("FAIL sat_clr: got %0d %0d v=%b expected 0 0 0", stat_br2, stat_mp2, bus2.out_valid_o); end
   endtask

   initial begin
      bus.in_valid_i = 1'b0; bus.op_i = '0; bus.op1_i = '0; bus.op2_i = '0; bus.pc_i = '0;
      bus.imm_i = '0; bus.pred_taken_i = 1'b0; bus.pred_target_i = '0; bus.out_ready_i = 1'b0;
      bus2.in_valid_i = 1'b0; bus2.op_i = '0; bus2.op1_i = '0; bus2.op2_i = '0; bus2.pc_i = '0;
      bus2.imm_i = '0; bus2.pred_taken_i = 1'b0; bus2.pred_target_i = '0; bus2.out_ready_i = 1'b0;
      test_reset();
      test_blt();
      test_bltu();
      test_jalr();
      test_ops();
      test_stall();
      test_flush_stall();
      test_back_to_back();
      test_reset_stall();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
